// File: rtl/bids22_model_if.sv
// rtl/bids22_model_if.sv - bidder and controller signal bundle for the bid-model auction engine
interface bids22_model_if;
  logic [15:0] X_bidAmt, Y_bidAmt, Z_bidAmt;
  logic        X_bid, Y_bid, Z_bid;
  logic        X_retract, Y_retract, Z_retract;
  logic [31:0] C_data;
  logic        C_start;
  logic [3:0]  C_op;
  logic        X_ack, Y_ack, Z_ack;
  logic [1:0]  X_err, Y_err, Z_err;
  logic [31:0] X_balance, Y_balance, Z_balance;
  logic        X_win, Y_win, Z_win;
  logic        ready;
  logic [2:0]  err;
  logic        roundOver;
  logic [31:0] maxBid;

  modport master (
    output X_bidAmt, Y_bidAmt, Z_bidAmt, X_bid, Y_bid, Z_bid,
           X_retract, Y_retract, Z_retract, C_data, C_start, C_op,
    input  X_ack, Y_ack, Z_ack, X_err, Y_err, Z_err,
           X_balance, Y_balance, Z_balance, X_win, Y_win, Z_win,
           ready, err, roundOver, maxBid
  );

  modport slave (
    input  X_bidAmt, Y_bidAmt, Z_bidAmt, X_bid, Y_bid, Z_bid,
           X_retract, Y_retract, Z_retract, C_data, C_start, C_op,
    output X_ack, Y_ack, Z_ack, X_err, Y_err, Z_err,
           X_balance, Y_balance, Z_balance, X_win, Y_win, Z_win,
           ready, err, roundOver, maxBid
  );
endinterface

// File: rtl/bids22_model.sv
// rtl/bids22_model.sv - three-bidder sealed-round auction engine
// Optional wrong-key lockout enabled by defining WRONG_KEY_LOCKOUT_EN.
module bids22_model #(
  parameter logic [31:0] DEFAULT_COST = 32'd1
`ifdef WRONG_KEY_LOCKOUT_EN
  , parameter int MAX_WRONG_KEYS = 3
  , parameter int LOCKOUT_CYCLES = 16
`endif
) (
  input logic           clk,
  input logic           reset_n,
  bids22_model_if.slave bus
);
  typedef enum logic [1:0] {S_UNLOCKED, S_LOCKED, S_BUSY} state_t;

  localparam logic [1:0] NO_LEADER   = 2'd3;
  localparam logic [3:0] OP_NOP      = 4'd0;
  localparam logic [3:0] OP_UNLOCK   = 4'd1;
  localparam logic [3:0] OP_LOCK     = 4'd2;
  localparam logic [3:0] OP_LOADX    = 4'd3;
  localparam logic [3:0] OP_LOADY    = 4'd4;
  localparam logic [3:0] OP_LOADZ    = 4'd5;
  localparam logic [3:0] OP_SET_COST = 4'd6;

  state_t      state_q, state_n;
  logic        locked_q, locked_n;
  logic [31:0] key_q, key_n, cost_q, cost_n, max_q, max_n;
  logic [31:0] bal_q [3];
  logic [31:0] bal_n [3];
  logic [15:0] held_q [3];
  logic [15:0] held_n [3];
  logic [1:0]  berr_q [3];
  logic [1:0]  berr_n [3];
  logic [15:0] amt [3];
  logic [2:0]  win_q, win_n, ack_q, ack_n, bid, retract;
  logic [1:0]  leader_q, leader_n;
  logic [2:0]  cerr_q, cerr_n;
  logic        round_over_q, round_over_n;
  logic        ready, accept, key_ok, lockout;

  assign bid     = {bus.Z_bid, bus.Y_bid, bus.X_bid};
  assign retract = {bus.Z_retract, bus.Y_retract, bus.X_retract};
  assign amt[0]  = bus.X_bidAmt;
  assign amt[1]  = bus.Y_bidAmt;
  assign amt[2]  = bus.Z_bidAmt;

  assign ready  = (state_q != S_BUSY);
  assign accept = bus.C_start && ready;
  assign key_ok = (bus.C_data == key_q);

`ifdef WRONG_KEY_LOCKOUT_EN
  logic [31:0] wrong_q, tmr_q;
  logic        unlock_try;

  assign lockout    = (tmr_q != 32'd0);
  assign unlock_try = accept && locked_q && (bus.C_op == OP_UNLOCK);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wrong_q <= '0;
      tmr_q   <= '0;
    end else begin
      if (tmr_q != 32'd0) tmr_q <= tmr_q - 32'd1;
      if (unlock_try && !lockout) begin
        if (key_ok) begin
          wrong_q <= '0;
        end else if (wrong_q + 32'd1 >= 32'(MAX_WRONG_KEYS)) begin
          wrong_q <= '0;
          tmr_q   <= 32'(LOCKOUT_CYCLES);
        end else begin
          wrong_q <= wrong_q + 32'd1;
        end
      end
    end
  end
`else
  assign lockout = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_UNLOCKED;
    else          state_q <= state_n;
  end

  always_comb begin
    state_n = state_q;
    case (state_q)
      S_UNLOCKED, S_LOCKED: if (accept) state_n = S_BUSY;
      S_BUSY:               state_n = locked_q ? S_LOCKED : S_UNLOCKED;
      default:              state_n = S_UNLOCKED;
    endcase
  end

  always_comb begin
    bal_n        = bal_q;
    held_n       = held_q;
    max_n        = max_q;
    leader_n     = leader_q;
    win_n        = win_q;
    key_n        = key_q;
    cost_n       = cost_q;
    locked_n     = locked_q;
    cerr_n       = cerr_q;
    ack_n        = '0;
    berr_n       = '{default: 2'd0};
    round_over_n = 1'b0;

    // Bidders are resolved in X, Y, Z order against the running maxBid.
    for (int i = 0; i < 3; i++) begin
      if (bid[i]) begin
        ack_n[i] = 1'b1;
        if (!locked_q)
          berr_n[i] = 2'd1;
        else if ({1'b0, bal_n[i]} < ({17'b0, amt[i]} + {1'b0, cost_q}))
          berr_n[i] = 2'd2;
        else if ({16'b0, amt[i]} <= max_n)
          berr_n[i] = 2'd3;
        else begin
          bal_n[i]  = bal_n[i] - cost_q;
          held_n[i] = amt[i];
          max_n     = {16'b0, amt[i]};
          leader_n  = 2'(i);
        end
      end else if (retract[i]) begin
        ack_n[i] = 1'b1;
        if (!locked_q)                berr_n[i] = 2'd1;
        else if (leader_n == 2'(i))   berr_n[i] = 2'd3;
        else                          held_n[i] = '0;
      end
    end

    if (accept) begin
      cerr_n = 3'd0;
      if (bus.C_op > OP_SET_COST) begin
        cerr_n = 3'd4;
      end else if (!locked_q) begin
        case (bus.C_op)
          OP_UNLOCK: cerr_n = 3'd2;
          OP_LOCK: begin
            key_n    = bus.C_data;
            held_n   = '{default: 16'd0};
            max_n    = '0;
            win_n    = '0;
            leader_n = NO_LEADER;
            locked_n = 1'b1;
          end
          OP_LOADX:    bal_n[0] = bus.C_data;
          OP_LOADY:    bal_n[1] = bus.C_data;
          OP_LOADZ:    bal_n[2] = bus.C_data;
          OP_SET_COST: cost_n   = bus.C_data;
          default: ;
        endcase
      end else begin
        case (bus.C_op)
          OP_NOP: ;
          OP_UNLOCK: begin
            if (lockout) begin
              cerr_n = 3'd5;
            end else if (key_ok) begin
              // Debit uses maxBid after this cycle's bids have been applied.
              round_over_n = 1'b1;
              for (int j = 0; j < 3; j++) begin
                if (leader_n == 2'(j)) begin
                  win_n[j] = 1'b1;
                  bal_n[j] = bal_n[j] - max_n;
                end
              end
              leader_n = NO_LEADER;
              locked_n = 1'b0;
            end else begin
              cerr_n = 3'd1;
            end
          end
          default: cerr_n = 3'd3;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      locked_q     <= 1'b0;
      key_q        <= '0;
      cost_q       <= DEFAULT_COST;
      max_q        <= '0;
      bal_q        <= '{default: 32'd0};
      held_q       <= '{default: 16'd0};
      berr_q       <= '{default: 2'd0};
      win_q        <= '0;
      ack_q        <= '0;
      leader_q     <= NO_LEADER;
      cerr_q       <= '0;
      round_over_q <= 1'b0;
    end else begin
      locked_q     <= locked_n;
      key_q        <= key_n;
      cost_q       <= cost_n;
      max_q        <= max_n;
      bal_q        <= bal_n;
      held_q       <= held_n;
      berr_q       <= berr_n;
      win_q        <= win_n;
      ack_q        <= ack_n;
      leader_q     <= leader_n;
      cerr_q       <= cerr_n;
      round_over_q <= round_over_n;
    end
  end

  assign bus.X_ack     = ack_q[0];
  assign bus.Y_ack     = ack_q[1];
  assign bus.Z_ack     = ack_q[2];
  assign bus.X_err     = berr_q[0];
  assign bus.Y_err     = berr_q[1];
  assign bus.Z_err     = berr_q[2];
  assign bus.X_balance = bal_q[0];
  assign bus.Y_balance = bal_q[1];
  assign bus.Z_balance = bal_q[2];
  assign bus.X_win     = win_q[0];
  assign bus.Y_win     = win_q[1];
  assign bus.Z_win     = win_q[2];
  assign bus.ready     = ready;
  assign bus.err       = cerr_q;
  assign bus.roundOver = round_over_q;
  assign bus.maxBid    = max_q;
endmodule

// File: doc/bids22_model.md
Name: bids22_model

Overview:
- Three-bidder (X, Y, Z) sealed-round auction engine: the responder side of the bid-model stimulus interface.
- A controller port loads balances, sets the bid fee, and locks/unlocks the round using a 32-bit key.
- Bidder ports submit or retract bids and receive registered ack/err responses.
- Top-level DUT under the UVM-style tester/bfm.

Parameters:
- DEFAULT_COST, 32'd1, per-bid fee loaded at reset.
- MAX_WRONG_KEYS, 3, wrong UNLOCK keys before lockout (optional feature only).
- LOCKOUT_CYCLES, 16, lockout duration in clocks (optional feature only).

Ports:
- clk  in  1  clock; single clock domain.
- reset_n  in  1  asynchronous, active-low reset.
- X_bidAmt/Y_bidAmt/Z_bidAmt  in  16 each  bid amount.
- X_bid/Y_bid/Z_bid  in  1 each  bid request, sampled every cycle.
- X_retract/Y_retract/Z_retract  in  1 each  retract request.
- C_data  in  32  controller operand.
- C_start  in  1  controller command strobe.
- C_op  in  4  0 NOP, 1 UNLOCK, 2 LOCK, 3 LOADX, 4 LOADY, 5 LOADZ, 6 SET_COST, 7-15 invalid.
- X_ack/Y_ack/Z_ack  out  1 each  one-cycle response pulse.
- X_err/Y_err/Z_err  out  2 each  0 ok, 1 round inactive, 2 insufficient funds, 3 bid too low / leader retract.
- X_balance/Y_balance/Z_balance  out  32 each  current balance.
- X_win/Y_win/Z_win  out  1 each  winner flag.
- ready  out  1  controller may issue a command.
- err  out  3  0 ok, 1 bad key, 2 already unlocked, 3 locked (LOCK/LOAD/SET while locked), 4 invalid op, 5 lockout.
- roundOver  out  1  one-cycle pulse at round end.
- maxBid  out  32  current or final highest bid, zero-extended.

Behaviour:
- Reset (async): state UNLOCKED, key=0, cost=DEFAULT_COST.
  - All balances, held bids, maxBid, acks, errs, win, roundOver = 0.
  - ready=1; leader=none.
- States: UNLOCKED, LOCKED, BUSY.
  - A command is accepted when C_start && ready. The FSM enters BUSY for one cycle with ready=0.
  - err and all state effects are registered on the accepting edge and visible the next cycle. err holds until the next accepted command.
  - C_start while ready=0 is ignored.
- UNLOCKED commands:
  - LOADx: balance=C_data.
  - SET_COST: cost=C_data.
  - LOCK: key=C_data; clear held bids, maxBid, win flags; go LOCKED.
  - UNLOCK: err=2.
- LOCKED commands:
  - UNLOCK with C_data==key ends the round:
    - roundOver pulses one cycle.
    - The leader's win=1 and its balance -= maxBid.
    - maxBid holds; go UNLOCKED.
  - UNLOCK with a wrong key: err=1, stays LOCKED.
  - LOCK, LOADx, SET_COST: err=3, no effect.
  - NOP: err=0.
  - Invalid op in any state: err=4.
- Round end with no bids: roundOver pulses, no win flag set, maxBid=0.
- Bidder responses: ack and err are registered one cycle after the request cycle; ack pulses for exactly one cycle per request cycle.
- Bid request:
  - If not LOCKED: err=1.
  - Else if {1'b0,balance} < {17'b0,bidAmt}+{1'b0,cost} (33-bit compare): err=2.
  - Else if bidAmt <= maxBid: err=3.
  - Else accept: balance -= cost, held bid = bidAmt, maxBid = bidAmt, leader = this bidder.
  - A leader may raise its own bid.
- Simultaneous bids in one cycle are evaluated in X, then Y, then Z order. Each is compared against maxBid as updated by the earlier ones in that cycle.
- Retract request:
  - If not LOCKED: err=1.
  - If the bidder is the leader: err=3, no change.
  - Otherwise clear its held bid: err=0, even if no bid was held.
- Bid and retract from the same bidder in one cycle: the bid is processed, the retract is ignored, and a single ack is issued.
- Bids arriving in the same cycle as the accepted UNLOCK are evaluated against pre-unlock state (still LOCKED). The round-end debit uses the resulting maxBid.
- Invariant: the winner's balance >= maxBid at round end, so no underflow.
- Win flags hold until the next LOCK or reset.
- Reset mid-round discards the round; no roundOver pulse.

Optional Feature:
- Macro WRONG_KEY_LOCKOUT_EN.
- With it: MAX_WRONG_KEYS consecutive wrong UNLOCK keys start a lockout timer.
  - During LOCKOUT_CYCLES clocks, UNLOCK commands return err=5 with no key compare.
  - The counter clears on a correct key or on reset.
  - Bidding is unaffected.
- Without it: wrong keys always return err=1 and there is no counter or timer logic.

Test Plan:
- Reset, LOADX 100, LOCK key 0xA5A5A5A5, X bids 10.
  - X_ack next cycle, X_err=0, X_balance=99, maxBid=10.
- Continue: Y (balance 0) bids 20 -> Y_err=2. Z (balance 50) bids 10 -> Z_err=3.
- X, Y, Z (balances 100 each) bid 5, 7, 7 in the same cycle.
  - X_err=0, Y_err=0, Z_err=3; maxBid=7, leader Y.
- Y retracts while leading -> Y_err=3. X retracts -> X_err=0.
- UNLOCK with key 0x1 -> err=1, stays locked.
- UNLOCK with 0xA5A5A5A5 -> roundOver pulse; Y_win=1; Y_balance=100-1-7=92.
- LOADX while locked -> err=3. UNLOCK while unlocked -> err=2. C_op=9 -> err=4.
- X bids while unlocked -> X_ack, X_err=1.
- Assert reset_n low mid-round -> all outputs zero and ready=1 immediately, asynchronously.
